// File: rtl/ccd_exposure_sequencer.sv
`timescale 1ns/1ps
// Frame acquisition sequencer around ccd_readout: flush passes, shutter-timed
// exposure, settle, then one digitising readout pass, with abort handling.
module ccd_exposure_sequencer #(
    parameter int TICK_DIV       = 50000,
    parameter int EXP_W          = 24,
    parameter int CLEAN_W        = 4,
    parameter int SHUTTER_SETTLE = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [EXP_W-1:0]   cmd_exp_ticks,
    input  logic [CLEAN_W-1:0] cmd_n_clean,
    input  logic               cmd_bin2x2,
    input  logic               abort,
    output logic               ro_toggle,
    output logic [1:0]         ro_mode,
    input  logic               ro_busy,
    output logic               shutter_open,
    output logic               frame_done,
    output logic               frame_aborted,
    output logic [2:0]         state_dbg
);

    localparam logic [1:0] ccd_mode_clean       = 2'd0;
    localparam logic [1:0] ccd_mode_readout_1x1 = 2'd1;
    localparam logic [1:0] ccd_mode_readout_2x2 = 2'd2;

    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] CLEAN_KICK = 4'd1;
    localparam logic [3:0] CLEAN_WAIT = 4'd2;
    localparam logic [3:0] EXP_START  = 4'd3;
    localparam logic [3:0] EXPOSE     = 4'd4;
    localparam logic [3:0] SETTLE     = 4'd5;
    localparam logic [3:0] READ_KICK  = 4'd6;
    localparam logic [3:0] READ_WAIT  = 4'd7;
    localparam logic [3:0] DRAIN      = 4'd8;

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = (SHUTTER_SETTLE < 1) ? 1 : $clog2(SHUTTER_SETTLE + 1);

    logic [3:0]         state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic               toggle_q, toggle_d;
    logic               shutter_q, shutter_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic [CLEAN_W-1:0] clean_q, clean_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic               bin_q, bin_d;
    logic [SW-1:0]      settle_q, settle_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic               tick;
    logic [1:0]         read_mode;

    assign tick      = (presc_q == PW'(TICK_DIV - 1));
    assign read_mode = bin_q ? ccd_mode_readout_2x2 : ccd_mode_readout_1x1;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        toggle_d  = toggle_q;
        shutter_d = shutter_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        clean_d   = clean_q;
        exp_d     = exp_q;
        bin_d     = bin_q;
        settle_d  = settle_q;
        presc_d   = tick ? '0 : presc_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                mode_d = ccd_mode_clean;
                if (cmd_valid) begin
                    clean_d = cmd_n_clean;
                    exp_d   = cmd_exp_ticks;
                    bin_d   = cmd_bin2x2;
                    if (cmd_n_clean != '0) begin
                        state_d  = CLEAN_KICK;
                        toggle_d = !ro_busy;
                    end else begin
                        state_d = EXP_START;
                    end
                end
            end
            CLEAN_KICK, READ_KICK: begin
                // toggle is only raised once any earlier pass has ended
                if (abort) begin
                    toggle_d = 1'b0;
                    state_d  = DRAIN;
                end else if (!toggle_q) begin
                    toggle_d = !ro_busy;
                end else if (ro_busy) begin
                    toggle_d = 1'b0;
                    state_d  = (state_q == CLEAN_KICK) ? CLEAN_WAIT : READ_WAIT;
                end
            end
            CLEAN_WAIT: begin
                if (abort) begin
                    state_d = DRAIN;
                end else if (!ro_busy) begin
                    clean_d = clean_q - 1'b1;
                    if (clean_q == CLEAN_W'(1)) begin
                        state_d = EXP_START;
                    end else begin
                        state_d  = CLEAN_KICK;
                        mode_d   = ccd_mode_clean;
                        toggle_d = 1'b1;
                    end
                end
            end
            EXP_START: begin
                if (abort) begin
                    shutter_d = 1'b0;
                    state_d   = DRAIN;
                end else if (exp_q == '0) begin
                    state_d  = READ_KICK;
                    mode_d   = read_mode;
                    toggle_d = !ro_busy;
                end else begin
                    shutter_d = 1'b1;
                    presc_d   = '0;
                    state_d   = EXPOSE;
                end
            end
            EXPOSE: begin
                if (abort) begin
                    shutter_d = 1'b0;
                    state_d   = DRAIN;
                end else if (tick) begin
                    exp_d = exp_q - 1'b1;
                    if (exp_q == EXP_W'(1)) begin
                        shutter_d = 1'b0;
                        presc_d   = '0;
                        settle_d  = SW'(SHUTTER_SETTLE);
                        state_d   = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (abort) begin
                    shutter_d = 1'b0;
                    state_d   = DRAIN;
                end else if (settle_q == '0) begin
                    state_d  = READ_KICK;
                    mode_d   = read_mode;
                    toggle_d = !ro_busy;
                end else if (tick) begin
                    settle_d = settle_q - 1'b1;
                end
            end
            READ_WAIT: begin
                // a finished readout outranks a coincident abort
                if (!ro_busy) begin
                    done_d  = 1'b1;
                    mode_d  = ccd_mode_clean;
                    state_d = IDLE;
                end else if (abort) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                toggle_d  = 1'b0;
                shutter_d = 1'b0;
                if (!ro_busy) begin
                    aborted_d = 1'b1;
                    mode_d    = ccd_mode_clean;
                    state_d   = IDLE;
                end
            end
            default: begin
                toggle_d  = 1'b0;
                shutter_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mode_q    <= ccd_mode_clean;
            toggle_q  <= 1'b0;
            shutter_q <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            clean_q   <= '0;
            exp_q     <= '0;
            bin_q     <= 1'b0;
            settle_q  <= '0;
            presc_q   <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            toggle_q  <= toggle_d;
            shutter_q <= shutter_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            clean_q   <= clean_d;
            exp_q     <= exp_d;
            bin_q     <= bin_d;
            settle_q  <= settle_d;
            presc_q   <= presc_d;
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign ro_toggle     = toggle_q;
    assign ro_mode       = mode_q;
    assign shutter_open  = shutter_q;
    assign frame_done    = done_q;
    assign frame_aborted = aborted_q;
    // DRAIN reports as READ_WAIT: both mean waiting on ccd_readout to finish
    assign state_dbg     = (state_q == DRAIN) ? 3'd7 : state_q[2:0];

endmodule

// File: tb/tb_ccd_exposure_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for ccd_exposure_sequencer with a simple ccd_readout model
// that stays busy for 10 cycles after each toggle.
module tb_ccd_exposure_sequencer;

    localparam int BUDGET = 1000;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] val;
    } ev_t;

    localparam logic [1:0] EV_TOG  = 2'd0;
    localparam logic [1:0] EV_DONE = 2'd1;
    localparam logic [1:0] EV_ABRT = 2'd2;
    localparam logic [1:0] EV_SHUT = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [23:0] cmd_exp_ticks = '0;
    logic [3:0]  cmd_n_clean = '0;
    logic        cmd_bin2x2 = 1'b0;
    logic        abort = 1'b0;
    logic        ro_toggle;
    logic [1:0]  ro_mode;
    logic        ro_busy;
    logic        shutter_open;
    logic        frame_done;
    logic        frame_aborted;
    logic [2:0]  state_dbg;

    int   tests = 0;
    int   fails = 0;
    ev_t  exp_q[$];
    int   busy_cnt = 0;

    ccd_exposure_sequencer #(
        .TICK_DIV(4),
        .EXP_W(24),
        .CLEAN_W(4),
        .SHUTTER_SETTLE(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_exp_ticks(cmd_exp_ticks),
        .cmd_n_clean(cmd_n_clean),
        .cmd_bin2x2(cmd_bin2x2),
        .abort(abort),
        .ro_toggle(ro_toggle),
        .ro_mode(ro_mode),
        .ro_busy(ro_busy),
        .shutter_open(shutter_open),
        .frame_done(frame_done),
        .frame_aborted(frame_aborted),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // readout model: independent of the sequencer reset
    always @(posedge clk) begin
        if (busy_cnt == 0 && ro_toggle) busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign ro_busy = (busy_cnt != 0);

    task automatic check(input bit ok, input string nm,
                         input longint act, input longint req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic push(input logic [1:0] k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [1:0] k, input int v, input string nm);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: unexpected event value %0d, required none", nm, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                fails++;
                $display("FAIL %s: got kind %0d val %0d, required kind %0d val %0d",
                         nm, k, v, e.kind, e.val);
            end
        end
    endtask

    // monitor: compares every DUT event against the scoreboard queue
    initial begin
        bit shut_prev = 0;
        bit tog_prev = 0;
        int shut_len = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                shut_prev = 0;
                tog_prev  = 0;
                shut_len  = 0;
            end else begin
                if (ro_toggle && !tog_prev) begin
                    check(!ro_busy, "toggle_while_busy", ro_busy, 0);
                    sb_pop(EV_TOG, int'(ro_mode), "toggle_mode");
                end
                if (frame_done) sb_pop(EV_DONE, 0, "frame_done");
                if (frame_aborted) sb_pop(EV_ABRT, 0, "frame_aborted");
                if (shutter_open) begin
                    shut_len++;
                end else if (shut_prev) begin
                    sb_pop(EV_SHUT, shut_len, "shutter_len");
                    shut_len = 0;
                end
                shut_prev = shutter_open;
                tog_prev  = ro_toggle;
            end
        end
    end

    task automatic wait_ready(input string nm);
        int t = 0;
        while (!cmd_ready && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        check(cmd_ready, nm, cmd_ready, 1);
    endtask

    task automatic send(input logic [23:0] e, input logic [3:0] n,
                        input logic b, input bit hold);
        wait_ready("cmd_ready_timeout");
        cmd_exp_ticks = e;
        cmd_n_clean   = n;
        cmd_bin2x2    = b;
        cmd_valid     = 1'b1;
        @(negedge clk);
        if (!hold) begin
            cmd_valid     = 1'b0;
            cmd_exp_ticks = 24'hABCDEF;
            cmd_n_clean   = 4'hF;
            cmd_bin2x2    = ~b;
        end
    endtask

    initial begin
        int k;
        bit early;
        repeat (2) @(negedge clk);
        check(cmd_ready == 1'b1, "rst_cmd_ready", cmd_ready, 1);
        check(ro_toggle == 1'b0, "rst_toggle", ro_toggle, 0);
        check(ro_mode == 2'd0, "rst_mode", ro_mode, 0);
        check(shutter_open == 1'b0, "rst_shutter", shutter_open, 0);
        check(frame_done == 1'b0, "rst_done", frame_done, 0);
        check(frame_aborted == 1'b0, "rst_aborted", frame_aborted, 0);
        check(state_dbg == 3'd0, "rst_state", state_dbg, 0);
        rst_n = 1'b1;

        // abort in IDLE does nothing
        abort = 1'b1;
        repeat (3) @(negedge clk);
        abort = 1'b0;
        check(state_dbg == 3'd0, "idle_abort_ignored", state_dbg, 0);

        // normal frame
        push(EV_TOG, 0); push(EV_TOG, 0); push(EV_SHUT, 20);
        push(EV_TOG, 1); push(EV_DONE, 0);
        send(24'd5, 4'd2, 1'b0, 0);
        wait_ready("normal_end");

        // bias frame
        push(EV_TOG, 2); push(EV_DONE, 0);
        send(24'd0, 4'd0, 1'b1, 0);
        k = 1;
        while (!ro_toggle && k < 10) begin
            @(negedge clk);
            k++;
        end
        check(k <= 2, "bias_toggle_latency", k, 2);
        wait_ready("bias_end");

        // abort during EXPOSE after two ticks
        push(EV_SHUT, 9); push(EV_ABRT, 0);
        send(24'd5, 4'd0, 1'b0, 0);
        k = 0;
        while (!shutter_open && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        check(shutter_open, "expose_open_timeout", shutter_open, 1);
        repeat (8) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check(shutter_open == 1'b0, "abort_shutter_closed", shutter_open, 0);
        wait_ready("abort_expose_end");

        // abort during READ_WAIT while busy: must drain first
        push(EV_TOG, 1); push(EV_ABRT, 0);
        send(24'd0, 4'd0, 1'b0, 0);
        k = 0;
        while (state_dbg != 3'd7 && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        early = 0;
        k = 0;
        while (ro_busy && k < BUDGET) begin
            if (frame_aborted || frame_done || cmd_ready) early = 1;
            @(negedge clk);
            k++;
        end
        check(!early, "read_wait_no_early_exit", early, 0);
        wait_ready("abort_read_end");

        // abort coincident with busy fall: done wins
        push(EV_TOG, 1); push(EV_DONE, 0);
        send(24'd0, 4'd0, 1'b0, 0);
        k = 0;
        while (state_dbg != 3'd7 && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        while (ro_busy && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_ready("coincident_end");

        // reset mid-EXPOSE
        send(24'd5, 4'd0, 1'b0, 0);
        k = 0;
        while (!shutter_open && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check(shutter_open == 1'b0, "async_rst_shutter", shutter_open, 0);
        check(ro_toggle == 1'b0, "async_rst_toggle", ro_toggle, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check(state_dbg == 3'd0, "post_rst_state", state_dbg, 0);
        check(cmd_ready == 1'b1, "post_rst_ready", cmd_ready, 1);

        // back-to-back with cmd_valid held high; fields change mid-frame
        push(EV_TOG, 0); push(EV_SHUT, 4); push(EV_TOG, 2); push(EV_DONE, 0);
        push(EV_TOG, 1); push(EV_DONE, 0);
        send(24'd1, 4'd1, 1'b1, 1);
        cmd_exp_ticks = 24'd0;
        cmd_n_clean   = 4'd0;
        cmd_bin2x2    = 1'b0;
        wait_ready("b2b_first_end");
        check(frame_done == 1'b1, "b2b_ready_with_done", frame_done, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check(cmd_ready == 1'b0, "b2b_second_accepted", cmd_ready, 0);
        wait_ready("b2b_second_end");

        k = 0;
        while (exp_q.size() != 0 && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ccd_exposure_sequencer.md
Name: ccd_exposure_sequencer

Overview:
- Sequences one complete CCD frame acquisition around the ccd_readout block.
- A frame is: N flush (clean) passes, shutter-timed exposure, then one digitising readout pass.
- Accepts one command from the host-side command decoder with a valid/ready handshake.
- Drives ccd_readout's toggle/mode inputs and the mechanical shutter, and reports frame completion and abort status.

Parameters:
- TICK_DIV, 50000, clk cycles per exposure tick (1 ms at 50 MHz); minimum 2.
- EXP_W, 24, width of the exposure-time field, in ticks.
- CLEAN_W, 4, width of the clean-pass count field.
- SHUTTER_SETTLE, 20, ticks waited after shutter close before readout starts.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_exp_ticks  in  EXP_W  exposure length in ticks; 0 means bias/dark frame, shutter stays closed.
- cmd_n_clean  in  CLEAN_W  number of clean passes before exposure; 0 allowed.
- cmd_bin2x2  in  1  1 = readout_2x2, 0 = readout_1x1.
- abort  in  1  level; cancels the frame in progress.
- ro_toggle  out  1  to ccd_readout toggle.
- ro_mode  out  2  to ccd_readout mode; uses the shared ccd_mode_* constants.
- ro_busy  in  1  from ccd_readout busy.
- shutter_open  out  1  shutter drive; 1 = open.
- frame_done  out  1  one-cycle pulse; readout completed normally.
- frame_aborted  out  1  one-cycle pulse; frame cancelled.
- state_dbg  out  3  current state encoding, for status register.

Behaviour:
- Reset (async assert, sync release) sets outputs: cmd_ready=1, ro_toggle=0, ro_mode=ccd_mode_clean, shutter_open=0, frame_done=0, frame_aborted=0, state=IDLE, all counters 0.
- Command handshake:
  - Accepted on the clk edge where cmd_valid && cmd_ready.
  - Fields are latched at acceptance. cmd_ready is 1 only in IDLE.
- Tick generator: free-running prescaler, cleared on entry to EXPOSE and SETTLE. tick pulses once every TICK_DIV cycles.
- States and transitions:
  - IDLE: on accept, go to CLEAN_KICK if n_clean>0, else to EXP_START.
  - CLEAN_KICK: ro_mode=clean, ro_toggle=1. Hold toggle until ro_busy=1, then toggle=0 and go to CLEAN_WAIT.
  - CLEAN_WAIT: when ro_busy=0, decrement the clean counter. If the count reaches 0, go to EXP_START; else go to CLEAN_KICK.
  - EXP_START (1 cycle): if exp_ticks=0, go to READ_KICK with shutter closed. Else set shutter_open=1, load the exposure counter, and go to EXPOSE.
  - EXPOSE: decrement on each tick. At 0, set shutter_open=0 and go to SETTLE. Shutter is open for exactly exp_ticks*TICK_DIV cycles (±1).
  - SETTLE: wait SHUTTER_SETTLE ticks, then go to READ_KICK.
  - READ_KICK: ro_mode = cmd_bin2x2 ? readout_2x2 : readout_1x1, ro_toggle=1 until ro_busy=1, then go to READ_WAIT.
  - READ_WAIT: on ro_busy falling to 0, pulse frame_done and go to IDLE. ro_mode then returns to clean.
- ro_mode changes only in IDLE or in the cycle entering a *_KICK state, never while ro_busy=1.
- ro_toggle is never asserted while ro_busy=1 from a previous pass. A KICK state entered with ro_busy still high waits for it to fall before raising toggle.
- Abort:
  - In CLEAN_KICK/CLEAN_WAIT/READ_KICK/READ_WAIT: drop toggle immediately and go to DRAIN. Readout cannot be interrupted.
  - In EXP_START/EXPOSE/SETTLE: set shutter_open=0 and go to DRAIN.
  - DRAIN: wait ro_busy=0, pulse frame_aborted, go to IDLE.
  - Abort in IDLE is ignored. Abort in the same cycle as acceptance is ignored; it takes effect the next cycle if still high.
- Simultaneous: if abort is asserted in the cycle READ_WAIT sees ro_busy=0, frame_done wins and frame_aborted is not pulsed.
- Counters saturate-free: maximum exp_ticks = 2^EXP_W−1. Maximum clean passes = 2^CLEAN_W−1.
- Reset mid-frame closes the shutter and deasserts toggle asynchronously. ccd_readout finishes its own pass independently.

Test Plan:
- Bench setup: TICK_DIV=4, SHUTTER_SETTLE=2, ro_busy model holds busy 10 cycles after toggle.
- Normal frame: exp=5, n_clean=2, bin=0 -> two toggles with mode=clean. shutter_open high exactly 20 cycles. Then one toggle with mode=readout_1x1. frame_done pulses once; cmd_ready returns to 1.
- Bias frame: exp=0, n_clean=0, bin=1 -> shutter never opens. Toggle with readout_2x2 within 2 cycles of acceptance. frame_done after busy falls.
- Abort during EXPOSE at tick 2 of 5 -> shutter closes the next cycle. No readout toggle. frame_aborted pulses once; returns to IDLE.
- Abort during READ_WAIT -> no early exit. Waits for busy=0. frame_aborted is not pulsed if coincident with busy fall (frame_done instead).
- Reset asserted mid-EXPOSE -> shutter_open=0, ro_toggle=0 with no clk edge. After release, state=IDLE and cmd_ready=1.
- Back-to-back commands with cmd_valid held high -> second accepted only after frame_done. The latched fields of frame 1 are unaffected by changes to the cmd_* inputs during the frame.
